// File: rtl/scie_cfir_pkg.sv
// Shared constants and types for the sequential complex-FIR SCIE unit.
// Opcodes, CONFIG field positions, FSM state and complex bundle.
package scie_cfir_pkg;

  localparam logic [6:0] OP_SETCOEF = 7'h0B;
  localparam logic [6:0] OP_PUSH    = 7'h2B;
  localparam logic [6:0] OP_READ    = 7'h5B;
  localparam logic [6:0] OP_CONFIG  = 7'h7B;

  localparam int CFG_SHIFT_W   = 6;
  localparam int CFG_CLEAR_BIT = 8;
  localparam int CFG_SAT_BIT   = 9;

  localparam int CPLX_W = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MAC  = 1'b1
  } state_e;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } complex_t;

endpackage

// File: rtl/scie_cfir_seq_cmac_term.sv
// Combinational complex multiply: one full-precision FIR term c*x.
// Output carries one guard bit above the raw product width.
module cmac_term #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] i_c_re,
  input  logic signed [DATA_W-1:0] i_c_im,
  input  logic signed [DATA_W-1:0] i_x_re,
  input  logic signed [DATA_W-1:0] i_x_im,
  output logic signed [2*DATA_W:0] o_t_re,
  output logic signed [2*DATA_W:0] o_t_im
);

  localparam int PW = 2 * DATA_W;
  localparam int TW = 2 * DATA_W + 1;

  logic signed [PW-1:0] w_rr;
  logic signed [PW-1:0] w_ii;
  logic signed [PW-1:0] w_ri;
  logic signed [PW-1:0] w_ir;

  assign w_rr = PW'(i_c_re) * PW'(i_x_re);
  assign w_ii = PW'(i_c_im) * PW'(i_x_im);
  assign w_ri = PW'(i_c_re) * PW'(i_x_im);
  assign w_ir = PW'(i_c_im) * PW'(i_x_re);

  assign o_t_re = TW'(w_rr) - TW'(w_ii);
  assign o_t_im = TW'(w_ri) + TW'(w_ir);

endmodule

// File: rtl/scie_cfir_seq.sv
// Sequential complex FIR custom-instruction unit: one shared complex
// MAC walks the taps, io_ready backpressures while it runs.
module scie_cfir_seq
  import scie_cfir_pkg::*;
#(
  parameter int TAPS   = 5,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 72,
  parameter int OUT_W  = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     io_valid,
  output logic                     io_ready,
  input  logic [31:0]              io_insn,
  input  logic signed [DATA_W-1:0] io_rs1_real,
  input  logic signed [DATA_W-1:0] io_rs1_imag,
  input  logic [31:0]              io_rs2,
  output logic signed [OUT_W-1:0]  io_rd_real,
  output logic signed [OUT_W-1:0]  io_rd_imag,
  output logic                     io_rd_valid
);

  localparam int KW = $clog2(TAPS);
  localparam int TW = 2 * DATA_W + 1;

  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  state_e r_state;
  state_e w_state_nxt;

  cplx_t r_coef [TAPS];
  cplx_t r_x    [TAPS];

  logic signed [ACC_W-1:0] r_acc_re;
  logic signed [ACC_W-1:0] r_acc_im;
  logic [KW-1:0]           r_k;
  logic signed [OUT_W-1:0] r_res_re;
  logic signed [OUT_W-1:0] r_res_im;
  logic signed [OUT_W-1:0] r_rd_re;
  logic signed [OUT_W-1:0] r_rd_im;
  logic                    r_rd_valid;
  logic [CFG_SHIFT_W-1:0]  r_shift;
  logic                    r_sat;

  logic [6:0] w_opc;
  logic       w_fire;
  logic       w_op_set;
  logic       w_op_push;
  logic       w_op_read;
  logic       w_op_cfg;
  logic       w_mac;
  logic       w_last;
  logic       w_unused;

  logic signed [TW-1:0]    w_t_re;
  logic signed [TW-1:0]    w_t_im;
  logic signed [ACC_W-1:0] w_sum_re;
  logic signed [ACC_W-1:0] w_sum_im;

  assign w_opc     = io_insn[6:0];
  assign w_fire    = io_valid & io_ready;
  assign w_op_set  = w_fire & (w_opc == OP_SETCOEF);
  assign w_op_push = w_fire & (w_opc == OP_PUSH);
  assign w_op_read = w_fire & (w_opc == OP_READ);
  assign w_op_cfg  = w_fire & (w_opc == OP_CONFIG);
  assign w_mac     = (r_state == S_MAC);
  assign w_last    = w_mac & (r_k == KW'(TAPS - 1));
  assign w_unused  = ^io_insn[31:7];

  cmac_term #(
    .DATA_W (DATA_W)
  ) u_term (
    .i_c_re (r_coef[r_k].re),
    .i_c_im (r_coef[r_k].im),
    .i_x_re (r_x[r_k].re),
    .i_x_im (r_x[r_k].im),
    .o_t_re (w_t_re),
    .o_t_im (w_t_im)
  );

  assign w_sum_re = r_acc_re + ACC_W'(w_t_re);
  assign w_sum_im = r_acc_im + ACC_W'(w_t_im);

  function automatic logic signed [OUT_W-1:0] fmt(
    input logic signed [ACC_W-1:0] a,
    input logic [CFG_SHIFT_W-1:0]  sh,
    input logic                    sat
  );
    logic signed [ACC_W-1:0] s;
    s = a >>> sh;
    if (sat && (s > MAXV)) s = MAXV;
    if (sat && (s < MINV)) s = MINV;
    return s[OUT_W-1:0];
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_op_push) w_state_nxt = S_MAC;
      S_MAC:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    io_ready = (r_state == S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_coef[i] <= '0;
        r_x[i]    <= '0;
      end
      r_acc_re   <= '0;
      r_acc_im   <= '0;
      r_k        <= '0;
      r_res_re   <= '0;
      r_res_im   <= '0;
      r_rd_re    <= '0;
      r_rd_im    <= '0;
      r_rd_valid <= 1'b0;
      r_shift    <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      unique case (1'b1)
        w_op_set: begin
          if (io_rs2 < 32'(TAPS)) begin
            r_coef[io_rs2[KW-1:0]].re <= io_rs1_real;
            r_coef[io_rs2[KW-1:0]].im <= io_rs1_imag;
          end
        end
        w_op_push: begin
          for (int i = TAPS - 1; i > 0; i--) r_x[i] <= r_x[i-1];
          r_x[0].re <= io_rs1_real;
          r_x[0].im <= io_rs1_imag;
          r_acc_re  <= '0;
          r_acc_im  <= '0;
          r_k       <= '0;
        end
        w_op_read: begin
          r_rd_re    <= r_res_re;
          r_rd_im    <= r_res_im;
          r_rd_valid <= 1'b1;
        end
        w_op_cfg: begin
          r_shift <= io_rs2[CFG_SHIFT_W-1:0];
          r_sat   <= io_rs2[CFG_SAT_BIT];
          if (io_rs2[CFG_CLEAR_BIT]) begin
            for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
          end
        end
        w_mac: begin
          r_acc_re <= w_sum_re;
          r_acc_im <= w_sum_im;
          r_k      <= r_k + 1'b1;
          if (w_last) begin
            r_res_re <= fmt(w_sum_re, r_shift, r_sat);
            r_res_im <= fmt(w_sum_im, r_shift, r_sat);
          end
        end
        default: ;
      endcase
    end
  end

  assign io_rd_real  = r_rd_re;
  assign io_rd_imag  = r_rd_im;
  assign io_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_scie_cfir_seq.sv
// Directed self-checking bench for scie_cfir_seq (TAPS=5, 32-bit data).
// Each task drives one scenario and checks hand-computed results.
module tb_scie_cfir_seq;

  localparam logic [6:0] OP_SET  = 7'h0B;
  localparam logic [6:0] OP_PUSH = 7'h2B;
  localparam logic [6:0] OP_READ = 7'h5B;
  localparam logic [6:0] OP_CFG  = 7'h7B;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               io_valid = 1'b0;
  logic [31:0]        io_insn = '0;
  logic signed [31:0] io_rs1_real = '0;
  logic signed [31:0] io_rs1_imag = '0;
  logic [31:0]        io_rs2 = '0;
  logic               io_ready;
  logic               io_rd_valid;
  logic signed [31:0] io_rd_real;
  logic signed [31:0] io_rd_imag;

  int tests = 0;
  int fails = 0;

  scie_cfir_seq #(
    .TAPS   (5),
    .DATA_W (32),
    .ACC_W  (72),
    .OUT_W  (32)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .io_valid    (io_valid),
    .io_ready    (io_ready),
    .io_insn     (io_insn),
    .io_rs1_real (io_rs1_real),
    .io_rs1_imag (io_rs1_imag),
    .io_rs2      (io_rs2),
    .io_rd_real  (io_rd_real),
    .io_rd_imag  (io_rd_imag),
    .io_rd_valid (io_rd_valid)
  );

  always #5 clock = ~clock;

  task automatic send(input logic [6:0] op, input logic signed [31:0] re,
                      input logic signed [31:0] im, input logic [31:0] rs2);
    int n;
    n = 0;
    @(negedge clock);
    while (io_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (io_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout got %0b exp 1", io_ready);
    end
    io_valid    = 1'b1;
    io_insn     = {25'd0, op};
    io_rs1_real = re;
    io_rs1_imag = im;
    io_rs2      = rs2;
    @(posedge clock);
    #1 io_valid = 1'b0;
  endtask

  task automatic do_read(output logic signed [31:0] re, output logic signed [31:0] im,
                         output logic v1, output logic v0);
    send(OP_READ, 0, 0, 0);
    re = io_rd_real;
    im = io_rd_imag;
    v1 = io_rd_valid;
    @(posedge clock);
    #1 v0 = io_rd_valid;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    tests++; if (io_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %0b exp 1", io_ready); end
    tests++; if (io_rd_valid !== 1'b0) begin fails++; $display("FAIL rst_rdv got %0b exp 0", io_rd_valid); end
    tests++; if (io_rd_real !== 32'sd0) begin fails++; $display("FAIL rst_re got %0d exp 0", io_rd_real); end
    tests++; if (io_rd_imag !== 32'sd0) begin fails++; $display("FAIL rst_im got %0d exp 0", io_rd_imag); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    logic signed [31:0] re, im;
    logic v1, v0;
    int n;
    send(OP_SET, 2, 0, 0);
    send(OP_PUSH, 3, 4, 0);
    n = 0;
    @(negedge clock);
    while (io_ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge clock);
    end
    tests++; if (n !== 5) begin fails++; $display("FAIL busy_cycles got %0d exp 5", n); end
    do_read(re, im, v1, v0);
    tests++; if (re !== 32'sd6) begin fails++; $display("FAIL basic_re got %0d exp 6", re); end
    tests++; if (im !== 32'sd8) begin fails++; $display("FAIL basic_im got %0d exp 8", im); end
    tests++; if (v1 !== 1'b1) begin fails++; $display("FAIL rdv_pulse got %0b exp 1", v1); end
    tests++; if (v0 !== 1'b0) begin fails++; $display("FAIL rdv_drop got %0b exp 0", v0); end
  endtask

  task automatic test_imag;
    logic signed [31:0] re, im;
    logic v1, v0;
    send(OP_SET, 0, 1, 0);
    send(OP_PUSH, 3, 4, 0);
    do_read(re, im, v1, v0);
    tests++; if (re !== -32'sd4) begin fails++; $display("FAIL imag_re got %0d exp -4", re); end
    tests++; if (im !== 32'sd3) begin fails++; $display("FAIL imag_im got %0d exp 3", im); end
  endtask

  task automatic test_taps;
    logic signed [31:0] re, im;
    logic v1, v0;
    send(OP_CFG, 0, 0, 32'h100);
    for (int i = 0; i < 5; i++) send(OP_SET, i + 1, 0, i);
    for (int i = 0; i < 5; i++) begin
      send(OP_PUSH, (i == 0) ? 1 : 0, 0, 0);
      do_read(re, im, v1, v0);
      tests++; if (re !== 32'(i + 1)) begin fails++; $display("FAIL tap%0d_re got %0d exp %0d", i, re, i + 1); end
      tests++; if (im !== 32'sd0) begin fails++; $display("FAIL tap%0d_im got %0d exp 0", i, im); end
    end
  endtask

  task automatic test_sat;
    logic signed [31:0] re, im;
    logic v1, v0;
    send(OP_CFG, 0, 0, 32'h100);
    send(OP_SET, 32'sh7FFFFFFF, 0, 0);
    send(OP_PUSH, 32'sh7FFFFFFF, 0, 0);
    do_read(re, im, v1, v0);
    tests++; if (re !== 32'sd1) begin fails++; $display("FAIL wrap_re got %0d exp 1", re); end
    tests++; if (im !== 32'sd0) begin fails++; $display("FAIL wrap_im got %0d exp 0", im); end
    send(OP_CFG, 0, 0, 32'h300);
    send(OP_PUSH, 32'sh7FFFFFFF, 0, 0);
    do_read(re, im, v1, v0);
    tests++; if (re !== 32'sh7FFFFFFF) begin fails++; $display("FAIL satp_re got %0h exp 7fffffff", re); end
    tests++; if (im !== 32'sd0) begin fails++; $display("FAIL satp_im got %0d exp 0", im); end
    send(OP_CFG, 0, 0, 32'h300);
    send(OP_PUSH, -32'sd2147483647, 0, 0);
    do_read(re, im, v1, v0);
    tests++; if (re !== 32'sh80000000) begin fails++; $display("FAIL satn_re got %0h exp 80000000", re); end
  endtask

  task automatic test_shift;
    logic signed [31:0] re, im;
    logic v1, v0;
    send(OP_CFG, 0, 0, 32'h104);
    send(OP_SET, 16, 0, 0);
    send(OP_PUSH, 5, 0, 0);
    do_read(re, im, v1, v0);
    tests++; if (re !== 32'sd5) begin fails++; $display("FAIL shift_re got %0d exp 5", re); end
    tests++; if (im !== 32'sd0) begin fails++; $display("FAIL shift_im got %0d exp 0", im); end
    send(OP_CFG, 0, 0, 32'h104);
    send(OP_PUSH, -5, 3, 0);
    do_read(re, im, v1, v0);
    tests++; if (re !== -32'sd5) begin fails++; $display("FAIL shneg_re got %0d exp -5", re); end
    tests++; if (im !== 32'sd3) begin fails++; $display("FAIL shneg_im got %0d exp 3", im); end
    send(OP_CFG, 0, 0, 32'h104);
    send(OP_PUSH, 0, 0, 0);
    do_read(re, im, v1, v0);
    tests++; if (re !== 32'sd0) begin fails++; $display("FAIL clear_re got %0d exp 0", re); end
    tests++; if (im !== 32'sd0) begin fails++; $display("FAIL clear_im got %0d exp 0", im); end
    send(OP_SET, 9, 9, 7);
    send(OP_SET, 9, 9, 8);
    send(OP_CFG, 0, 0, 32'h104);
    send(OP_PUSH, 5, 0, 0);
    do_read(re, im, v1, v0);
    tests++; if (re !== 32'sd5) begin fails++; $display("FAIL oob_re got %0d exp 5", re); end
    tests++; if (im !== 32'sd0) begin fails++; $display("FAIL oob_im got %0d exp 0", im); end
    send(OP_CFG, 0, 0, 32'h000);
    send(7'h33, 0, 0, 0);
    do_read(re, im, v1, v0);
    tests++; if (re !== 32'sd5) begin fails++; $display("FAIL keep_re got %0d exp 5", re); end
  endtask

  task automatic test_reset_mid;
    logic signed [31:0] re, im;
    logic v1, v0;
    send(OP_CFG, 0, 0, 32'h204);
    send(OP_PUSH, 3, 4, 0);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    tests++; if (io_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got %0b exp 1", io_ready); end
    tests++; if (io_rd_real !== 32'sd0) begin fails++; $display("FAIL midrst_rd got %0d exp 0", io_rd_real); end
    @(negedge clock);
    reset_n = 1'b1;
    do_read(re, im, v1, v0);
    tests++; if (re !== 32'sd0) begin fails++; $display("FAIL midrst_re got %0d exp 0", re); end
    tests++; if (im !== 32'sd0) begin fails++; $display("FAIL midrst_im got %0d exp 0", im); end
    tests++; if (v1 !== 1'b1) begin fails++; $display("FAIL midrst_rdv got %0b exp 1", v1); end
    for (int i = 0; i < 5; i++) begin
      send(OP_PUSH, (i == 0) ? 1 : 0, 0, 0);
      do_read(re, im, v1, v0);
      tests++; if (re !== 32'sd0) begin fails++; $display("FAIL zc%0d_re got %0d exp 0", i, re); end
      tests++; if (im !== 32'sd0) begin fails++; $display("FAIL zc%0d_im got %0d exp 0", i, im); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_imag;
    test_taps;
    test_sat;
    test_shift;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
